edgedet_multi: RTL and testbench
================================

Name: edgedet_multi

Overview:
- Multi-channel, parametrised successor to the single-signal edge detector.
- Per channel:
  - synchronises an asynchronous input with a configurable-depth flop chain;
  - debounces it with a stability counter;
  - reports selectable rising, falling or both edges as one-cycle pulses plus sticky, software-clearable pending flags.
- Sits between raw board inputs (buttons, encoders, external strobes) and control FSMs or interrupt logic.

Parameters:
- NUM_CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STEPS, 2: synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a changed synchronised value must persist before it is accepted (>=1).
- RESET_LEVEL, 0: reset value of synchroniser flops and debounced level, identical for all channels.

Ports:
- in_clk  input  1  system clock; all state on rising edge.
- in_rstn  input  1  asynchronous active-low reset.
- in_signal  input  NUM_CHANNELS  raw asynchronous inputs, bit i = channel i.
- in_mode  input  2*NUM_CHANNELS  per-channel edge select, bits [2i+1:2i]:
  - 00 none
  - 01 rising
  - 10 falling
  - 11 both
- in_clear  input  NUM_CHANNELS  synchronous clear of pending flags, bit i = channel i.
- out_level  output  NUM_CHANNELS  debounced level.
- out_edge  output  NUM_CHANNELS  one-cycle edge pulse per channel.
- out_pending  output  NUM_CHANNELS  sticky edge flags.
- out_any  output  1  OR of out_pending.

Behaviour:
- Reset (async assert, sync release irrelevant — flops use async clear/preset):
  - synchroniser flops = RESET_LEVEL; out_level = RESET_LEVEL.
  - debounce counters = 0.
  - out_edge = 0, out_pending = 0, out_any = 0.
- Synchroniser: shift chain per channel; s_i = last stage.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If s_i == out_level[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: out_level[i] <= s_i, counter <= 0, change accepted.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (s_i returns before acceptance) resets the counter and produces no level change or edge.
- Latency: a clean input transition settled before rising edge k changes out_level on edge k+SYNC_STEPS+DEBOUNCE_CYCLES-1. out_edge is asserted in the same cycle out_level changes.
- Edge: out_edge[i] is registered and high for exactly one cycle when a change is accepted and in_mode selects it:
  - rising = accepted new level 1 with mode bit0;
  - falling = accepted new level 0 with mode bit1.
  - in_mode is sampled on the acceptance edge. Changing mode never generates a pulse retroactively.
- Pending flags:
  - out_pending[i] <= 1 on the edge where out_edge[i] is set.
  - Else out_pending[i] <= 0 when in_clear[i] = 1.
  - Simultaneous set and clear: set wins, flag stays 1.
- out_any: registered OR of the next pending values, so it is coincident with out_pending.
- Channels are fully independent; simultaneous events on all channels are handled in the same cycle.
- Reset mid-operation: all counters are abandoned and no pulse is emitted. After release, if an input differs from RESET_LEVEL, it is reported as a normal edge after full latency.
- Input toggling continuously faster than DEBOUNCE_CYCLES: out_level stays constant and no edges are reported.

Test Plan (NUM_CHANNELS=4, SYNC_STEPS=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0):
- Reset, in_signal=0000, mode=all 11 -> all outputs 0; then ch0 0->1 before edge k -> out_level[0]=1 and a single out_edge[0] pulse at edge k+5, out_pending[0]=1, out_any=1.
- ch1 pulse high for 3 cycles, mode 01 -> out_level[1], out_edge[1] and out_pending[1] stay 0. Same pulse held 4 cycles -> one edge, at latency 5.
- ch2 mode 01, rise then fall (each held 10 cycles) -> exactly one out_edge[2] (rise). Repeat with mode 10 -> only fall reported; with mode 00 -> none, but out_level[2] still tracks.
- out_pending[0]=1, in_clear[0]=1 for one cycle -> pending 0 and out_any 0 next cycle. in_clear[3] asserted in the same cycle ch3 reports an edge -> out_pending[3] remains 1.
- All four channels rise on the same cycle, mode 11 -> out_edge=1111 for one cycle, out_pending=1111.
- in_rstn asserted while ch0 counter=2 with input high -> outputs 0 immediately, no pulse. After release with input still high -> out_edge[0] at 5 edges after release.

Source files
------------

// File: rtl/edgedet_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : edgedet_multi_if
//  Purpose  : Bundles the per-channel inputs and outputs of edgedet_multi so
//             the detector and its user share one parameterised connection.
//  Signals  : in_signal   [N-1:0]   raw asynchronous inputs, bit i = channel i
//             in_mode     [2N-1:0]  edge select per channel, [2i+1:2i]
//                                   00 none, 01 rising, 10 falling, 11 both
//             in_clear    [N-1:0]   synchronous clear of pending flags
//             out_level   [N-1:0]   debounced level
//             out_edge    [N-1:0]   one-cycle edge pulse
//             out_pending [N-1:0]   sticky edge flags
//             out_any               OR of out_pending
//  Modports : master = user side (drives inputs), slave = detector side.
//  Revision : 1.0 - initial release
// ============================================================================
interface edgedet_multi_if #(
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0]   in_signal;
  logic [2*NUM_CHANNELS-1:0] in_mode;
  logic [NUM_CHANNELS-1:0]   in_clear;
  logic [NUM_CHANNELS-1:0]   out_level;
  logic [NUM_CHANNELS-1:0]   out_edge;
  logic [NUM_CHANNELS-1:0]   out_pending;
  logic                      out_any;

  modport master (
    output in_signal, in_mode, in_clear,
    input  out_level, out_edge, out_pending, out_any
  );

  modport slave (
    input  in_signal, in_mode, in_clear,
    output out_level, out_edge, out_pending, out_any
  );
endinterface
`default_nettype wire

// File: rtl/edgedet_multi.sv
`default_nettype none
// ============================================================================
//  Module   : edgedet_multi
//  Purpose  : Multi-channel synchronising, debouncing edge detector. Each
//             channel passes its raw input through a flop chain, accepts a
//             new level only after it has persisted DEBOUNCE_CYCLES cycles,
//             and reports selected rising/falling edges as one-cycle pulses
//             plus sticky, software-clearable pending flags.
//  Ports    : in_clk   system clock, all state on rising edge
//             in_rstn  asynchronous active-low reset
//             bus      edgedet_multi_if.slave carrying in_signal, in_mode,
//                      in_clear, out_level, out_edge, out_pending, out_any
//  Revision : 1.0 - initial release
// ============================================================================
module edgedet_multi #(
  parameter int NUM_CHANNELS    = 4,
  parameter int SYNC_STEPS      = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  wire logic         in_clk,
  input  wire logic         in_rstn,
  edgedet_multi_if.slave    bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CHANNELS-1:0] level_vec;
  logic [NUM_CHANNELS-1:0] edge_vec;
  logic [NUM_CHANNELS-1:0] pend_vec;
  logic [NUM_CHANNELS-1:0] pend_next;
  logic                    any_q;

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic [SYNC_STEPS-1:0] sync_q;
      logic [CNT_W-1:0]      cnt_q;
      logic                  level_q;
      logic                  edge_q;
      logic                  pend_q;
      logic                  sync_out;
      logic                  accept;
      logic                  mode_hit;
      logic                  pend_set;

      assign sync_out = sync_q[SYNC_STEPS-1];
      // The counter only advances while the synchronised value differs from
      // the level, so reaching CNT_LAST with a difference still present means
      // DEBOUNCE_CYCLES consecutive differing samples.
      assign accept   = (sync_out != level_q) && (cnt_q == CNT_LAST);
      // The new level after acceptance is sync_out: 1 -> rising, 0 -> falling.
      assign mode_hit = sync_out ? bus.in_mode[2*i] : bus.in_mode[2*i+1];
      assign pend_set = accept & mode_hit;
      // Set has priority over a coincident clear.
      assign pend_next[i] = pend_set | (pend_q & ~bus.in_clear[i]);

      always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
          sync_q <= {SYNC_STEPS{RESET_LEVEL}};
        end else begin
          sync_q <= {sync_q[SYNC_STEPS-2:0], bus.in_signal[i]};
        end
      end

      always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
          cnt_q   <= '0;
          level_q <= RESET_LEVEL;
          edge_q  <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          edge_q <= pend_set;
          pend_q <= pend_next[i];
          if (sync_out == level_q) begin
            cnt_q <= '0;
          end else if (accept) begin
            level_q <= sync_out;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign level_vec[i] = level_q;
      assign edge_vec[i]  = edge_q;
      assign pend_vec[i]  = pend_q;
    end
  endgenerate

  // Registered from the next-state pending vector so it lines up with
  // out_pending rather than lagging it by a cycle.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pend_next;
    end
  end

  assign bus.out_level   = level_vec;
  assign bus.out_edge    = edge_vec;
  assign bus.out_pending = pend_vec;
  assign bus.out_any     = any_q;

endmodule
`default_nettype wire

// File: tb/tb_edgedet_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edgedet_multi
//  Purpose  : Self-checking bench for edgedet_multi with a window-based
//             reference model (a level is accepted once the last
//             DEBOUNCE_CYCLES synchronised samples all differ from it).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edgedet_multi;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam bit RL = 1'b0;
  localparam int H  = SS + DC - 1;

  logic in_clk  = 1'b0;
  logic in_rstn = 1'b0;

  edgedet_multi_if #(.NUM_CHANNELS(N)) bus ();

  edgedet_multi #(
    .NUM_CHANNELS   (N),
    .SYNC_STEPS     (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (RL)
  ) dut (
    .in_clk (in_clk),
    .in_rstn(in_rstn),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: hist[ch][0] is the most recent raw sample.
  bit             hist [N][H];
  logic [N-1:0]   m_level, m_edge, m_pend;
  logic           m_any;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < H; j++) hist[c][j] = RL;
    m_level = {N{RL}};
    m_edge  = '0;
    m_pend  = '0;
    m_any   = 1'b0;
  endtask

  // Evaluated at a rising clock edge with the inputs present at that edge.
  task automatic model_edge();
    if (in_rstn) begin
      for (int c = 0; c < N; c++) begin
        bit acc;
        acc = 1'b1;
        // Sample used at this edge is the one taken SS edges ago.
        for (int j = 0; j < DC; j++)
          if (hist[c][SS-1+j] == m_level[c]) acc = 1'b0;
        if (acc) begin
          m_level[c] = ~m_level[c];
          m_edge[c]  = m_level[c] ? bus.in_mode[2*c] : bus.in_mode[2*c+1];
        end else begin
          m_edge[c] = 1'b0;
        end
        if (m_edge[c]) m_pend[c] = 1'b1;
        else if (bus.in_clear[c]) m_pend[c] = 1'b0;
        for (int j = H-1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = bus.in_signal[c];
      end
      m_any = |m_pend;
    end
  endtask

  task automatic compare_all();
    check("level",   32'(bus.out_level),   32'(m_level));
    check("edge",    32'(bus.out_edge),    32'(m_edge));
    check("pending", 32'(bus.out_pending), 32'(m_pend));
    check("any",     32'(bus.out_any),     32'(m_any));
  endtask

  task automatic tick();
    @(posedge in_clk);
    model_edge();
    @(negedge in_clk);
    compare_all();
  endtask

  int edges_seen;
  logic [N-1:0] hold_left [N];

  initial begin
    bus.in_signal = '0;
    bus.in_mode   = 8'hFF;
    bus.in_clear  = '0;
    model_reset();
    #1;
    compare_all();
    check("rst_all_zero", 32'({bus.out_level, bus.out_edge, bus.out_pending, bus.out_any}), 32'd0);
    tick(); tick();
    in_rstn = 1'b1;
    repeat (3) tick();

    // ch0 rising edge: latency SS+DC-1 = 5 after the capturing edge k.
    bus.in_signal[0] = 1'b1;
    repeat (5) tick();
    check("ch0_pre_level", 32'(bus.out_level[0]), 32'd0);
    tick();
    check("ch0_level", 32'(bus.out_level[0]), 32'd1);
    check("ch0_edge",  32'(bus.out_edge[0]),  32'd1);
    check("ch0_pend",  32'(bus.out_pending[0]), 32'd1);
    check("ch0_any",   32'(bus.out_any), 32'd1);
    tick();
    check("ch0_edge_one_cycle", 32'(bus.out_edge[0]), 32'd0);

    // ch1 glitch of 3 cycles, rising-only mode: rejected.
    bus.in_mode[3:2] = 2'b01;
    bus.in_signal[1] = 1'b1;
    repeat (3) tick();
    bus.in_signal[1] = 1'b0;
    repeat (8) tick();
    check("ch1_glitch_level", 32'(bus.out_level[1]), 32'd0);
    check("ch1_glitch_pend",  32'(bus.out_pending[1]), 32'd0);
    // 4-cycle pulse: accepted, edge at the 6th edge after the rise.
    bus.in_signal[1] = 1'b1;
    repeat (4) tick();
    bus.in_signal[1] = 1'b0;
    tick();
    check("ch1_pulse4_noedge_yet", 32'(bus.out_edge[1]), 32'd0);
    tick();
    check("ch1_pulse4_edge", 32'(bus.out_edge[1]), 32'd1);
    repeat (10) tick();
    check("ch1_back_low", 32'(bus.out_level[1]), 32'd0);

    // ch1 toggling faster than the debounce window.
    for (int i = 0; i < 24; i++) begin
      bus.in_signal[1] = i[1];
      tick();
      check("ch1_toggle_level", 32'(bus.out_level[1]), 32'd0);
    end
    bus.in_signal[1] = 1'b0;

    // ch2 under modes 01, 10, 00.
    for (int m = 0; m < 3; m++) begin
      bus.in_mode[5:4] = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : 2'b00;
      edges_seen = 0;
      bus.in_signal[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.out_edge[2]) edges_seen++;
      end
      check("ch2_level_high", 32'(bus.out_level[2]), 32'd1);
      bus.in_signal[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.out_edge[2]) begin
          edges_seen++;
          check("ch2_fall_level", 32'(bus.out_level[2]), 32'd0);
        end
      end
      check("ch2_edge_count", 32'(edges_seen), (m == 2) ? 32'd0 : 32'd1);
    end

    // Clearing pending flags.
    bus.in_clear = 4'b1110;
    tick();
    bus.in_clear = '0;
    check("clear_others", 32'(bus.out_pending), 32'b0001);
    bus.in_clear = 4'b0001;
    tick();
    bus.in_clear = '0;
    check("clear_ch0_pend", 32'(bus.out_pending[0]), 32'd0);
    check("clear_ch0_any",  32'(bus.out_any), 32'd0);

    // ch3 edge coincident with clear: set wins.
    bus.in_signal[3] = 1'b1;
    repeat (5) tick();
    bus.in_clear[3] = 1'b1;
    tick();
    bus.in_clear[3] = 1'b0;
    check("ch3_set_clear_edge", 32'(bus.out_edge[3]), 32'd1);
    check("ch3_set_clear_pend", 32'(bus.out_pending[3]), 32'd1);

    // All channels rise together.
    bus.in_mode   = 8'hFF;
    bus.in_signal = '0;
    repeat (10) tick();
    bus.in_clear = 4'hF;
    tick();
    bus.in_clear = '0;
    bus.in_signal = 4'hF;
    repeat (5) tick();
    tick();
    check("all_edge", 32'(bus.out_edge),    32'hF);
    check("all_pend", 32'(bus.out_pending), 32'hF);
    tick();
    check("all_edge_gone", 32'(bus.out_edge), 32'h0);

    // Reset in the middle of a debounce.
    bus.in_signal = '0;
    repeat (10) tick();
    bus.in_clear = 4'hF;
    tick();
    bus.in_clear = '0;
    bus.in_signal[0] = 1'b1;
    repeat (4) tick();
    in_rstn = 1'b0;
    #1;
    model_reset();
    check("midrst_outputs", 32'({bus.out_level, bus.out_edge, bus.out_pending, bus.out_any}), 32'd0);
    @(negedge in_clk);
    compare_all();
    tick(); tick();
    in_rstn = 1'b1;
    repeat (5) tick();
    check("midrst_no_early_edge", 32'(bus.out_edge[0]), 32'd0);
    tick();
    check("midrst_edge_after_release", 32'(bus.out_edge[0]), 32'd1);

    // Randomised phase: random hold lengths, modes, clears, one reset pulse.
    for (int c = 0; c < N; c++) hold_left[c] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          bus.in_signal[c] = ~bus.in_signal[c];
          hold_left[c] = N'($urandom_range(1, 9));
        end else begin
          hold_left[c] = hold_left[c] - 1'b1;
        end
      end
      if (cyc % 40 == 0) bus.in_mode = 8'($urandom);
      bus.in_clear = (($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      if (cyc == 300) begin
        in_rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge in_clk);
      end
      if (cyc == 303) in_rstn = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
